spi_xfer_arbiter: RTL and testbench

- Sequencing controller for the AES SPI link: owns chip-select, serial clock and bit count, and runs one full-width MSB-first SPI frame per grant.
- Shares the single SPI link between two requesters, encrypt path (0) and decrypt path (1), with round-robin arbitration.
- Loads the granted requester's word, shifts it out on mosi while capturing miso, then returns the received word with a one-cycle done pulse.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_shifter.sv | 57 +++++
 rtl/spi_xfer_arbiter.sv | 163 ++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the AES SPI link sequencer.
// Contents:
//   state_t      - frame sequencing states
//   REQ_ENC/DEC  - requester indices (encrypt path 0, decrypt path 1)
//   DEF_DATASIZE - default frame width (AES block/key width)
//   DEF_GAP      - default idle cycles between frames
//   req_onehot   - requester index to one-hot grant vector
package spi_pkg;

  // The ST_ prefix keeps these names apart from the GAP parameter of the top.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_t;

  localparam int REQ_ENC      = 0;
  localparam int REQ_DEC      = 1;
  localparam int DEF_DATASIZE = 128;
  localparam int DEF_GAP      = 2;

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// Serial datapath for one SPI frame: shift register, mosi register and bit
// counter. All sequencing decisions come from the arbiter FSM.
// Ports:
//   clk, rst   - system clock, synchronous active-low reset
//   load       - capture load_word, present its MSB on mosi, clear the count
//   shift_en   - rising-sclk cycle: shift miso in at the LSB, count one bit
//   out_en     - falling-sclk cycle: present the current MSB on mosi
//   clear      - frame finished: return mosi to 0
//   load_word  - word to transmit
//   miso       - serial data in
//   mosi       - serial data out (registered)
//   shreg      - shift register contents (received word at frame end)
//   bit_cnt    - bits captured so far in this frame
module spi_shifter
  import spi_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE,
  localparam int CW = $clog2(DATASIZE + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift_en,
  input  logic                out_en,
  input  logic                clear,
  input  logic [DATASIZE-1:0] load_word,
  input  logic                miso,
  output logic                mosi,
  output logic [DATASIZE-1:0] shreg,
  output logic [CW-1:0]       bit_cnt
);

  // The same register serves transmit and receive: the MSB leaves on mosi
  // while miso enters at the LSB, so after DATASIZE shifts it holds rx data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg   <= '0;
      mosi    <= 1'b0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= load_word;
      mosi    <= load_word[DATASIZE-1];
      bit_cnt <= '0;
    end else begin
      if (shift_en) begin
        shreg   <= {shreg[DATASIZE-2:0], miso};
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (out_en) begin
        mosi <= shreg[DATASIZE-1];
      end else if (clear) begin
        mosi <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Sequencing controller for the AES SPI link. Two requesters (encrypt 0,
// decrypt 1) share one link under round-robin arbitration; each grant runs
// one full-width MSB-first frame and returns the received word.
// Ports:
//   clk, rst  - system clock, synchronous active-low reset
//   req       - level requests, bit0 encrypt, bit1 decrypt (sampled only
//               when a new frame can be arbitrated)
//   tx0, tx1  - words to send, sampled in LOAD only
//   grant     - one-hot owner of the current frame, 0 when idle
//   done      - one-cycle pulse on the owner's bit at frame completion
//   rx_data   - received word, valid from done until the next DONE
//   busy      - frame activity (LOAD, SHIFT, DONE, GAP)
//   sclk, scs - SPI clock (idles low) and active-low chip select
//   mosi/miso - serial data out / in
module spi_xfer_arbiter
  import spi_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE,
  parameter int GAP      = DEF_GAP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [DATASIZE-1:0] tx0,
  input  logic [DATASIZE-1:0] tx1,
  output logic [1:0]          grant,
  output logic [1:0]          done,
  output logic [DATASIZE-1:0] rx_data,
  output logic                busy,
  output logic                sclk,
  output logic                scs,
  output logic                mosi,
  input  logic                miso
);

  localparam int CW = $clog2(DATASIZE + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t              state, next_state;
  logic                winner;
  logic                rr_ptr;
  logic                arb_ptr;
  logic                win_idx;
  logic                arb;
  logic [GW-1:0]       gap_cnt;
  logic                gap_last;
  logic                frame_end;
  logic                sh_load, sh_shift, sh_out, sh_clear;
  logic [DATASIZE-1:0] shreg;
  logic [CW-1:0]       bit_cnt;

  assign gap_last  = (int'(gap_cnt) == GAP - 1);
  assign frame_end = sclk && (bit_cnt == CW'(DATASIZE));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. The last inter-frame cycle (DONE when GAP is 0, else
  // the final GAP cycle) arbitrates directly, so scs stays high for exactly
  // GAP+1 cycles between back-to-back frames.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (req != 2'b00) next_state = ST_LOAD;
      ST_LOAD:  next_state = ST_SHIFT;
      ST_SHIFT: if (frame_end) next_state = ST_DONE;
      ST_DONE: begin
        if (GAP == 0) begin
          next_state = (req != 2'b00) ? ST_LOAD : ST_IDLE;
        end else begin
          next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          next_state = (req != 2'b00) ? ST_LOAD : ST_IDLE;
        end
      end
      default:  next_state = ST_IDLE;
    endcase
  end

  // Control strobes and arbitration. In DONE the round-robin pointer is
  // being updated this very edge, so arbitration uses its new value.
  always_comb begin
    busy     = (state != ST_IDLE);
    sh_load  = (state == ST_LOAD);
    sh_shift = (state == ST_SHIFT) && !sclk;
    sh_out   = (state == ST_SHIFT) && sclk;
    sh_clear = (state == ST_DONE);
    arb      = (next_state == ST_LOAD);
    arb_ptr  = (state == ST_DONE) ? ~winner : rr_ptr;
    case (req)
      2'b01:   win_idx = 1'(REQ_ENC);
      2'b10:   win_idx = 1'(REQ_DEC);
      default: win_idx = arb_ptr;
    endcase
  end

  // Registered link outputs and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant   <= 2'b00;
      done    <= 2'b00;
      rx_data <= '0;
      sclk    <= 1'b0;
      scs     <= 1'b1;
      winner  <= 1'b0;
      rr_ptr  <= 1'b0;
      gap_cnt <= '0;
    end else begin
      done <= 2'b00;
      if (arb) begin
        winner <= win_idx;
      end
      case (state)
        ST_LOAD: begin
          grant <= req_onehot(winner);
          scs   <= 1'b0;
          sclk  <= 1'b0;
        end
        ST_SHIFT: begin
          sclk <= ~sclk;
        end
        ST_DONE: begin
          scs     <= 1'b1;
          rx_data <= shreg;
          done    <= grant;
          grant   <= 2'b00;
          rr_ptr  <= ~winner;
          gap_cnt <= '0;
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
        end
        default: ;
      endcase
    end
  end

  spi_shifter #(
    .DATASIZE(DATASIZE)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .shift_en (sh_shift),
    .out_en   (sh_out),
    .clear    (sh_clear),
    .load_word(winner ? tx1 : tx0),
    .miso     (miso),
    .mosi     (mosi),
    .shreg    (shreg),
    .bit_cnt  (bit_cnt)
  );

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter. Three instances share clk and rst:
//   dut a - DATASIZE=8,   GAP=2
//   dut b - DATASIZE=8,   GAP=0
//   dut c - DATASIZE=128, GAP=2, miso driven by a reference slave
module tb_spi_xfer_arbiter;

  localparam logic [127:0] MASTER_WORD = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] SLAVE_WORD  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  logic         clk = 1'b0;
  logic         rst = 1'b0;

  logic [1:0]   req_a = 2'b00, grant_a, done_a;
  logic [7:0]   tx0_a = '0, tx1_a = '0, rx_a;
  logic         busy_a, sclk_a, scs_a, mosi_a, miso_a;
  logic         loop_a = 1'b1, fix_a = 1'b0;

  logic [1:0]   req_b = 2'b00, grant_b, done_b;
  logic [7:0]   tx0_b = 8'hFF, tx1_b = '0, rx_b;
  logic         busy_b, sclk_b, scs_b, mosi_b, miso_b;

  logic [1:0]   req_c = 2'b00, grant_c, done_c;
  logic [127:0] tx0_c = '0, tx1_c = '0, rx_c;
  logic         busy_c, sclk_c, scs_c, mosi_c, miso_c;
  logic [127:0] slave_reg;

  int checks = 0;
  int errors = 0;

  int first_grant, rises, scs_low, done_cyc, done_cnt, ng, nd, ngap, hi_run;
  logic prev_sclk, seen_low;
  logic [1:0] grant_val, done_val, prev_grant;
  logic [7:0] mosi_seq;
  logic [1:0] grants [4];
  logic [7:0] rxs [3];
  int gaps [3];

  always #5 clk = ~clk;

  assign miso_a = loop_a ? mosi_a : fix_a;
  assign miso_b = 1'b0;
  assign miso_c = slave_reg[127];

  // Reference slave: presents its MSB, shifts on each falling sclk.
  always @(posedge clk) begin
    if (!rst) slave_reg <= SLAVE_WORD;
    else if (sclk_c) slave_reg <= {slave_reg[126:0], 1'b0};
  end

  spi_xfer_arbiter #(.DATASIZE(8), .GAP(2)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .tx0(tx0_a), .tx1(tx1_a),
    .grant(grant_a), .done(done_a), .rx_data(rx_a), .busy(busy_a),
    .sclk(sclk_a), .scs(scs_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_xfer_arbiter #(.DATASIZE(8), .GAP(0)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .tx0(tx0_b), .tx1(tx1_b),
    .grant(grant_b), .done(done_b), .rx_data(rx_b), .busy(busy_b),
    .sclk(sclk_b), .scs(scs_b), .mosi(mosi_b), .miso(miso_b)
  );

  spi_xfer_arbiter #(.DATASIZE(128), .GAP(2)) u_dut_c (
    .clk(clk), .rst(rst), .req(req_c), .tx0(tx0_c), .tx1(tx1_c),
    .grant(grant_c), .done(done_c), .rx_data(rx_c), .busy(busy_c),
    .sclk(sclk_c), .scs(scs_c), .mosi(mosi_c), .miso(miso_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] ra, input logic [1:0] rb,
                               input logic [1:0] rc);
    req_a = ra;
    req_b = rb;
    req_c = rc;
  endtask

  task automatic doReset();
    applyStimulus(2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset values
    step();
    step();
    checkOutput("rst grant", grant_a, 2'b00);
    checkOutput("rst done", done_a, 2'b00);
    checkOutput("rst rx_data", rx_a, 8'h00);
    checkOutput("rst busy", busy_a, 1'b0);
    checkOutput("rst sclk", sclk_a, 1'b0);
    checkOutput("rst scs", scs_a, 1'b1);
    checkOutput("rst mosi", mosi_a, 1'b0);
    checkOutput("rst scs c", scs_c, 1'b1);
    rst = 1'b1;

    // Single frame, requester 0, miso looped back from mosi
    $display("[TB] single frame A5 loopback");
    tx0_a = 8'hA5;
    applyStimulus(2'b01, 2'b00, 2'b00);
    step();
    applyStimulus(2'b00, 2'b00, 2'b00);
    first_grant = -1; rises = 0; prev_sclk = 1'b0; scs_low = 0;
    done_cyc = -1; done_cnt = 0; done_val = 2'b00; mosi_seq = '0; grant_val = '0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (grant_a != 2'b00 && first_grant < 0) begin
        first_grant = c;
        grant_val = grant_a;
      end
      if (sclk_a && !prev_sclk) begin
        if (rises < 8) mosi_seq[7-rises] = mosi_a;
        rises++;
      end
      prev_sclk = sclk_a;
      if (!scs_a) scs_low++;
      if (done_a != 2'b00) begin
        done_cnt++;
        done_cyc = c;
        done_val = done_a;
      end
    end
    checkOutput("t1 grant cycle", first_grant, 1);
    checkOutput("t1 grant value", grant_val, 2'b01);
    checkOutput("t1 mosi bits", mosi_seq, 8'hA5);
    checkOutput("t1 sclk pulses", rises, 8);
    checkOutput("t1 done cycle", done_cyc, 18);
    checkOutput("t1 done value", done_val, 2'b01);
    checkOutput("t1 done count", done_cnt, 1);
    checkOutput("t1 rx_data", rx_a, 8'hA5);
    checkOutput("t1 scs low", scs_low, 17);
    checkOutput("t1 busy idle", busy_a, 1'b0);

    // Reset mid-SHIFT at bit 4; round-robin pointer currently favours 1
    $display("[TB] reset mid-frame");
    applyStimulus(2'b01, 2'b00, 2'b00);
    step();
    applyStimulus(2'b00, 2'b00, 2'b00);
    repeat (8) step();
    checkOutput("t4 sclk mid", sclk_a, 1'b1);
    checkOutput("t4 scs mid", scs_a, 1'b0);
    rst = 1'b0;
    step();
    checkOutput("t4 scs", scs_a, 1'b1);
    checkOutput("t4 sclk", sclk_a, 1'b0);
    checkOutput("t4 grant", grant_a, 2'b00);
    checkOutput("t4 busy", busy_a, 1'b0);
    checkOutput("t4 mosi", mosi_a, 1'b0);
    rst = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done_a != 2'b00) done_cnt++;
    end
    checkOutput("t4 no done", done_cnt, 0);
    applyStimulus(2'b11, 2'b00, 2'b00);
    step();
    step();
    checkOutput("t4 restart grant", grant_a, 2'b01);
    applyStimulus(2'b00, 2'b00, 2'b00);
    repeat (25) step();

    // Both requesters held, miso tied high
    $display("[TB] round robin");
    doReset();
    loop_a = 1'b0; fix_a = 1'b1;
    tx0_a = 8'h3C; tx1_a = 8'hC3;
    applyStimulus(2'b11, 2'b00, 2'b00);
    step();
    ng = 0; nd = 0; ngap = 0; hi_run = 0; seen_low = 1'b0; prev_grant = 2'b00;
    for (int c = 1; c <= 65; c++) begin
      step();
      if (grant_a != 2'b00 && prev_grant == 2'b00) begin
        if (ng < 4) grants[ng] = grant_a;
        ng++;
      end
      prev_grant = grant_a;
      if (done_a != 2'b00) begin
        if (nd < 3) rxs[nd] = rx_a;
        nd++;
      end
      if (scs_a) hi_run++;
      else begin
        if (hi_run > 0 && seen_low && ngap < 3) begin
          gaps[ngap] = hi_run;
          ngap++;
        end
        hi_run = 0;
        seen_low = 1'b1;
      end
    end
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("t2 grant count", ng, 4);
    checkOutput("t2 grant 0", grants[0], 2'b01);
    checkOutput("t2 grant 1", grants[1], 2'b10);
    checkOutput("t2 grant 2", grants[2], 2'b01);
    checkOutput("t2 done count", nd, 3);
    checkOutput("t2 gap count", ngap, 3);
    checkOutput("t2 gap 0", gaps[0], 3);
    checkOutput("t2 gap 1", gaps[1], 3);
    checkOutput("t2 rx 0", rxs[0], 8'hFF);
    checkOutput("t2 rx 1", rxs[1], 8'hFF);
    checkOutput("t2 rx 2", rxs[2], 8'hFF);

    // Requester 1 pulsed for a single cycle
    $display("[TB] one-cycle request");
    doReset();
    loop_a = 1'b1;
    applyStimulus(2'b10, 2'b00, 2'b00);
    step();
    applyStimulus(2'b00, 2'b00, 2'b00);
    first_grant = -1; grant_val = '0; done_cnt = 0; done_cyc = -1; done_val = '0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (grant_a != 2'b00 && first_grant < 0) begin
        first_grant = c;
        grant_val = grant_a;
      end
      if (done_a != 2'b00) begin
        done_cnt++;
        done_cyc = c;
        done_val = done_a;
      end
    end
    checkOutput("t3 grant value", grant_val, 2'b10);
    checkOutput("t3 done count", done_cnt, 1);
    checkOutput("t3 done value", done_val, 2'b10);
    checkOutput("t3 done cycle", done_cyc, 18);
    checkOutput("t3 rx_data", rx_a, 8'hC3);

    // GAP=0, requester 0 held, miso low
    $display("[TB] back-to-back GAP=0");
    applyStimulus(2'b00, 2'b01, 2'b00);
    step();
    ng = 0; nd = 0; ngap = 0; hi_run = 0; seen_low = 1'b0; prev_grant = 2'b00;
    first_grant = -1;
    for (int c = 1; c <= 55; c++) begin
      step();
      if (grant_b != 2'b00 && prev_grant == 2'b00) begin
        if (first_grant < 0) first_grant = c;
        ng++;
      end
      prev_grant = grant_b;
      if (done_b != 2'b00) nd++;
      if (scs_b) hi_run++;
      else begin
        if (hi_run > 0 && seen_low && ngap < 3) begin
          gaps[ngap] = hi_run;
          ngap++;
        end
        hi_run = 0;
        seen_low = 1'b1;
      end
    end
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("t5 first grant", first_grant, 1);
    checkOutput("t5 grant count", ng, 4);
    checkOutput("t5 done count", nd, 3);
    checkOutput("t5 gap count", ngap, 3);
    checkOutput("t5 gap 0", gaps[0], 1);
    checkOutput("t5 gap 1", gaps[1], 1);
    checkOutput("t5 rx_data", rx_b, 8'h00);

    // Full-width frame against the reference slave
    $display("[TB] 128-bit frame");
    doReset();
    tx0_c = MASTER_WORD;
    applyStimulus(2'b00, 2'b00, 2'b01);
    step();
    applyStimulus(2'b00, 2'b00, 2'b00);
    done_cnt = 0; done_cyc = -1; done_val = '0;
    for (int c = 1; c <= 265; c++) begin
      step();
      if (done_c != 2'b00) begin
        done_cnt++;
        done_cyc = c;
        done_val = done_c;
      end
    end
    checkOutput("t6 done cycle", done_cyc, 258);
    checkOutput("t6 done count", done_cnt, 1);
    checkOutput("t6 done value", done_val, 2'b01);
    checkOutput("t6 rx_data", rx_c, SLAVE_WORD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
